// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads one instruction word at pc, resolves
// indirect addressing through a second memory read, and reports the
// instruction and effective address with a one-cycle done pulse.
module fetch_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_adress,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ea,
    output logic              indirect,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        F_ADDR,
        F_WAIT,
        DEC,
        I_ADDR,
        I_WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              ind_q, ind_d;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            ea_q    <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            ind_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ea_q    <= ea_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            ind_q   <= ind_d;
        end
    end

    // Next-state and next-datapath logic; everything holds unless a state acts on it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ea_d    = ea_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        ind_d   = ind_q;
        unique case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_in;
                end
                if (start) begin
                    addr_d  = pc_load ? pc_in : pc_q;
                    rd_d    = 1'b1;
                    state_d = F_ADDR;
                end
            end
            F_ADDR: state_d = F_WAIT;
            F_WAIT: begin
                ir_d    = mem_rdata;
                rd_d    = 1'b0;
                state_d = DEC;
            end
            DEC: begin
                if (ir_q[15] && (ir_q[14:12] != 3'b111)) begin
                    addr_d  = ir_q[ADDR_W-1:0];
                    rd_d    = 1'b1;
                    ind_d   = 1'b1;
                    state_d = I_ADDR;
                end else begin
                    ea_d    = ir_q[ADDR_W-1:0];
                    ind_d   = 1'b0;
                    state_d = DONE;
                end
            end
            I_ADDR: state_d = I_WAIT;
            I_WAIT: begin
                ea_d    = mem_rdata[ADDR_W-1:0];
                rd_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                pc_d    = pc_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_adress = addr_q;
    assign mem_read   = rd_q;
    assign mem_write  = 1'b0;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign ea         = ea_q;
    assign indirect   = ind_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule
